// File: rtl/vend_pkg.sv
// Shared types, coin encoding and pricing helpers for the vending controller.
package vend_pkg;

    localparam logic [1:0] Coin100  = 2'd0;
    localparam logic [1:0] Coin500  = 2'd1;
    localparam logic [1:0] Coin1000 = 2'd2;
    localparam logic [1:0] CoinBad  = 2'd3;

    typedef enum logic [0:0] {StIdle, StChange} state_e;

    function automatic int unsigned coin_units(logic [1:0] code);
        case (code)
            Coin100:  return 1;
            Coin500:  return 5;
            Coin1000: return 10;
            default:  return 0;
        endcase
    endfunction

    function automatic int unsigned price(int unsigned base, int unsigned step,
                                          int unsigned idx);
        return base + idx * step;
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Bank of per-product stock counters with reset/refill load and one-hot decrement.
module vend_stock
    import vend_pkg::*;
#(
    parameter int unsigned N_PROD     = 5,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              refill,
    input  logic [N_PROD-1:0] dec,
    output logic [N_PROD-1:0] stock_empty
);

    logic [STOCK_W-1:0] stock_q [N_PROD];

    always_ff @(posedge clk) begin
        if (!rst_n || refill) begin
            for (int i = 0; i < int'(N_PROD); i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            // Guard keeps an empty counter from wrapping.
            for (int i = 0; i < int'(N_PROD); i++) begin
                if (dec[i] && stock_q[i] != '0) begin
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_PROD); i++) begin
            stock_empty[i] = (stock_q[i] == '0);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Multi-product vending controller: event arbiter, credit register, FSM and
// largest-coin-first change dispenser.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned N_PROD     = 5,
    parameter int unsigned CREDIT_W   = 6,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 4,
    parameter int unsigned PRICE_BASE = 1,
    parameter int unsigned PRICE_STEP = 1,
    localparam int unsigned IdxW      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [IdxW-1:0]     sel_idx,
    input  logic                change_req,
    input  logic                refill,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_PROD-1:0]   can_buy,
    output logic [N_PROD-1:0]   stock_empty,
    output logic                vend_valid,
    output logic [IdxW-1:0]     vend_idx,
    output logic                coin_reject,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    input  logic                chg_ready
);

    localparam int unsigned CreditMax = (32'd1 << CREDIT_W) - 32'd1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_valid_q, vend_valid_d;
    logic [IdxW-1:0]     vend_idx_q, vend_idx_d;
    logic                coin_reject_q, coin_reject_d;
    logic [N_PROD-1:0]   dec;
    logic                refill_en;
    logic                sel_ok;
    logic                coin_ok;
    int unsigned         sel_price;

    vend_stock #(
        .N_PROD     (N_PROD),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk         (clk),
        .rst_n       (rst_n),
        .refill      (refill_en),
        .dec         (dec),
        .stock_empty (stock_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            vend_valid_q  <= 1'b0;
            vend_idx_q    <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_valid_q  <= vend_valid_d;
            vend_idx_q    <= vend_idx_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // Change coin is a pure function of remaining credit, so it holds while stalled.
    always_comb begin
        chg_valid = (state_q == StChange);
        chg_coin  = Coin100;
        if (state_q == StChange) begin
            if (32'(credit_q) >= 32'd10) begin
                chg_coin = Coin1000;
            end else if (32'(credit_q) >= 32'd5) begin
                chg_coin = Coin500;
            end
        end
    end

    always_comb begin
        sel_price = price(PRICE_BASE, PRICE_STEP, 32'(sel_idx));
        sel_ok    = (32'(sel_idx) < N_PROD) && (32'(credit_q) >= sel_price) &&
                    !stock_empty[sel_idx];
        coin_ok   = (coin_code != CoinBad) &&
                    (32'(credit_q) + coin_units(coin_code) <= CreditMax);
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_valid_d  = 1'b0;
        vend_idx_d    = '0;
        coin_reject_d = 1'b0;
        dec           = '0;
        refill_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (change_req) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != '0) begin
                        state_d = StChange;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (sel_ok) begin
                        credit_d     = credit_q - CREDIT_W'(sel_price);
                        dec[sel_idx] = 1'b1;
                        vend_valid_d = 1'b1;
                        vend_idx_d   = sel_idx;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = credit_q + CREDIT_W'(coin_units(coin_code));
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (refill) begin
                    refill_en = 1'b1;
                end
            end
            StChange: begin
                coin_reject_d = coin_valid;
                if (chg_ready) begin
                    credit_d = credit_q - CREDIT_W'(coin_units(chg_coin));
                    if (credit_d == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < int'(N_PROD); i++) begin
            can_buy[i] = (state_q == StIdle) &&
                         (32'(credit_q) >= price(PRICE_BASE, PRICE_STEP, unsigned'(i))) &&
                         !stock_empty[i];
        end
    end

    assign credit      = credit_q;
    assign vend_valid  = vend_valid_q;
    assign vend_idx    = vend_idx_q;
    assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: expected output events are queued by the
// stimulus and popped by a negedge monitor; credit/stock levels are checked directly.
module tb_vend_controller;

    localparam int KVend = 0;
    localparam int KRej  = 1;
    localparam int KChg  = 2;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       sel_valid;
    logic [2:0] sel_idx;
    logic       change_req;
    logic       refill;
    logic [5:0] credit;
    logic [4:0] can_buy;
    logic [4:0] stock_empty;
    logic       vend_valid;
    logic [2:0] vend_idx;
    logic       coin_reject;
    logic       chg_valid;
    logic [1:0] chg_coin;
    logic       chg_ready;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    vend_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .change_req  (change_req),
        .refill      (refill),
        .credit      (credit),
        .can_buy     (can_buy),
        .stock_empty (stock_empty),
        .vend_valid  (vend_valid),
        .vend_idx    (vend_idx),
        .coin_reject (coin_reject),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .chg_ready   (chg_ready)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int actual, int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic expect_event(int kind, int val);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d actual_val=%0d required=none",
                     kind, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL event_match actual_kind=%0d actual_val=%0d required_kind=%0d required_val=%0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic push(int kind, int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Output monitor: same-cycle events are compared vend, reject, change in that order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vend_valid) expect_event(KVend, int'(vend_idx));
            if (coin_reject) expect_event(KRej, 0);
            if (chg_valid && chg_ready) expect_event(KChg, int'(chg_coin));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        coin_valid = 1'b0;
        coin_code  = 2'd0;
        sel_valid  = 1'b0;
        sel_idx    = 3'd0;
        change_req = 1'b0;
        refill     = 1'b0;
    endtask

    task automatic coin(logic [1:0] code, bit rejected);
        coin_valid = 1'b1;
        coin_code  = code;
        if (rejected) push(KRej, 0);
        tick();
        clear_inputs();
    endtask

    task automatic sel(logic [2:0] idx, bit vends);
        sel_valid = 1'b1;
        sel_idx   = idx;
        if (vends) push(KVend, int'(idx));
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        chg_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_credit", int'(credit), 0);
        check("reset_chg_valid", int'(chg_valid), 0);
        check("reset_vend_valid", int'(vend_valid), 0);
        check("reset_coin_reject", int'(coin_reject), 0);
        check("reset_stock_empty", int'(stock_empty), 0);
        check("reset_can_buy", int'(can_buy), 0);

        // Two 500 coins
        coin(2'd1, 0);
        coin(2'd1, 0);
        check("credit_10", int'(credit), 10);
        check("can_buy_all", int'(can_buy), 5'b11111);
        check("stock_full", int'(stock_empty), 0);

        // Product 4 costs 5
        sel(3'd4, 1);
        check("credit_after_buy4", int'(credit), 5);
        sel(3'd4, 1);
        check("credit_after_2nd_buy4", int'(credit), 0);
        sel(3'd4, 0);
        check("credit_after_3rd_buy4", int'(credit), 0);

        // Credit 7, change with ready high: 500, 100, 100
        coin(2'd1, 0);
        coin(2'd0, 0);
        coin(2'd0, 0);
        check("credit_7", int'(credit), 7);
        chg_ready  = 1'b1;
        change_req = 1'b1;
        push(KChg, 1);
        push(KChg, 0);
        push(KChg, 0);
        tick();
        clear_inputs();
        check("chg_valid_after_req", int'(chg_valid), 1);
        check("chg_coin_first", int'(chg_coin), 1);
        tick();
        tick();
        tick();
        chg_ready = 1'b0;
        check("credit_after_change", int'(credit), 0);
        check("chg_valid_done", int'(chg_valid), 0);
        check("can_buy_after_change", int'(can_buy), 0);

        // Credit 60, overflow and invalid coins
        for (int i = 0; i < 6; i++) coin(2'd2, 0);
        check("credit_60", int'(credit), 60);
        coin(2'd2, 1);
        check("credit_after_overflow", int'(credit), 60);
        coin(2'd3, 1);
        check("credit_after_bad_coin", int'(credit), 60);

        // Change with hopper stalled; coin during change is rejected
        change_req = 1'b1;
        tick();
        clear_inputs();
        check("stall_coin_0", int'(chg_coin), 2);
        coin_valid = 1'b1;
        coin_code  = 2'd0;
        push(KRej, 0);
        tick();
        clear_inputs();
        check("stall_coin_1", int'(chg_coin), 2);
        check("stall_valid", int'(chg_valid), 1);
        tick();
        check("stall_coin_2", int'(chg_coin), 2);
        check("credit_during_stall", int'(credit), 60);
        chg_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(KChg, 2);
        for (int i = 0; i < 6; i++) tick();
        chg_ready = 1'b0;
        check("credit_after_60_change", int'(credit), 0);
        check("chg_valid_after_60", int'(chg_valid), 0);

        // Exhaust product 0 from credit 5
        coin(2'd1, 0);
        for (int i = 0; i < 4; i++) sel(3'd0, 1);
        sel(3'd0, 0);
        check("credit_after_exhaust", int'(credit), 1);
        check("stock_empty_0", int'(stock_empty), 5'b00001);
        check("can_buy_exhausted", int'(can_buy), 0);
        refill = 1'b1;
        tick();
        clear_inputs();
        check("stock_after_refill", int'(stock_empty), 0);
        check("can_buy_after_refill", int'(can_buy), 5'b00001);

        // Coin and selection together: selection wins, coin rejected
        coin_valid = 1'b1;
        coin_code  = 2'd0;
        sel_valid  = 1'b1;
        sel_idx    = 3'd0;
        push(KVend, 0);
        push(KRej, 0);
        tick();
        clear_inputs();
        check("credit_after_collision", int'(credit), 0);

        // Change request with zero credit does nothing
        change_req = 1'b1;
        tick();
        clear_inputs();
        check("zero_credit_change", int'(chg_valid), 0);

        // Reset mid-change forfeits credit
        coin(2'd2, 0);
        coin(2'd0, 0);
        check("credit_11", int'(credit), 11);
        change_req = 1'b1;
        tick();
        clear_inputs();
        check("midchange_valid", int'(chg_valid), 1);
        rst_n = 1'b0;
        tick();
        check("reset_midchange_credit", int'(credit), 0);
        check("reset_midchange_chg_valid", int'(chg_valid), 0);
        rst_n = 1'b1;
        tick();
        tick();

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Parametrised multi-product candy vending controller, the successor to the fixed five-product `candy_control`. It accepts coded coin and selection events, tracks credit and per-product stock, and issues a one-cycle vend pulse per purchase. Change is returned through a valid/ready coin-dispense handshake, largest coin first. It sits between the front-panel input decoder and the dispenser/coin-hopper drivers.

## Interface
Parameters:
- `N_PROD`, 5: number of products (1..16).
- `CREDIT_W`, 6: credit register width, in units of 100; maximum credit is 2^CREDIT_W-1.
- `STOCK_W`, 4: per-product stock counter width.
- `STOCK_INIT`, 4: stock loaded at reset and on refill.
- `PRICE_BASE`, 1: price of product 0, in units.
- `PRICE_STEP`, 1: price increment per product index; price(i) = PRICE_BASE + i*PRICE_STEP.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `coin_valid`, in, 1: coin inserted this cycle.
- `coin_code`, in, 2: 0 = 100 (1 unit), 1 = 500 (5 units), 2 = 1000 (10 units), 3 = invalid.
- `sel_valid`, in, 1: vend request this cycle.
- `sel_idx`, in, clog2(N_PROD): requested product.
- `change_req`, in, 1: return all credit.
- `refill`, in, 1: reload every stock counter to STOCK_INIT.
- `credit`, out, CREDIT_W: current credit in units.
- `can_buy`, out, N_PROD: bit i set when product i is purchasable now.
- `stock_empty`, out, N_PROD: bit i set when stock[i] == 0.
- `vend_valid`, out, 1: one-cycle dispense pulse.
- `vend_idx`, out, clog2(N_PROD): product being dispensed; valid while `vend_valid` is high.
- `coin_reject`, out, 1: one-cycle pulse when an inserted coin is not accepted.
- `chg_valid`, out, 1: change coin offered.
- `chg_coin`, out, 2: coin code offered; held stable while `chg_valid` is high.
- `chg_ready`, in, 1: hopper accepts the offered coin.

## Operation
- State machine states: IDLE and CHANGE. Reset enters IDLE.
- IDLE event priority, highest first: change_req, then sel_valid, then coin_valid, then refill. Only one event is serviced per cycle.
  - A coin that loses arbitration pulses `coin_reject`.
  - A losing selection or refill is dropped.
- Coin, IDLE only: accepted if the code is valid and credit + value ≤ 2^CREDIT_W-1. Credit then becomes credit + value. Otherwise pulse `coin_reject` and leave credit unchanged.
- Selection, IDLE only: accepted if sel_idx < N_PROD, credit ≥ price(sel_idx) and stock[sel_idx] ≠ 0. On acceptance:
  - credit -= price(sel_idx);
  - stock[sel_idx] -= 1;
  - `vend_valid` pulses with `vend_idx` = sel_idx.
  - Otherwise no effect and no error output.
- Change request: credit = 0 leaves the block in IDLE with no output. Otherwise go to CHANGE.
- CHANGE state:
  - Offer the largest coin with value ≤ credit (1000, then 500, then 100).
  - On each cycle with `chg_valid` && `chg_ready`, subtract that coin's value from credit.
  - When credit reaches 0, return to IDLE.
  - While in CHANGE, coins are rejected, and selections and refills are ignored.
- `can_buy[i]` = (state == IDLE) && credit ≥ price(i) && stock[i] ≠ 0. This is combinational from registered state.
- Stock never underflows. Refill overrides current stock values.

## Timing
- Reset values:
  - credit = 0; stock = STOCK_INIT for every product; state = IDLE;
  - `vend_valid`, `coin_reject` and `chg_valid` = 0; `vend_idx` and `chg_coin` = 0.
- Latency from the event cycle:
  - Coin: credit updates on the next clock edge. `coin_reject` is asserted in the cycle after the event.
  - Selection: credit and stock update, and `vend_valid` asserts, one cycle after the request.
  - Change: `chg_valid` asserts one cycle after `change_req`.
- Change handshake:
  - `chg_coin` is stable while `chg_valid` is high and `chg_ready` is low.
  - On a completing handshake, the next coin is offered in the following cycle with no gap.
  - After the last coin, `chg_valid` deasserts in the following cycle.
- Reset asserted mid-change: outputs drop to reset values on the next edge; the remaining credit is forfeited.
- Back-to-back selections in consecutive cycles are each evaluated against the already updated credit and stock.

## Structure
- Package `vend_pkg` holds:
  - coin code constants and a coin-to-units function;
  - the state enumeration;
  - the price(i) function of PRICE_BASE and PRICE_STEP.
- Sub-module `vend_stock`: a bank of N_PROD stock counters with reset/refill load, a one-hot decrement, and a zero-flag vector.
- The arbiter, credit register, FSM and change logic stay in the top level.

## Test plan
All scenarios use default parameters.
- Reset, then coins 500, 500 → credit = 10; `can_buy` = 5'b11111; `stock_empty` = 0.
- From credit 10: select product 4 (price 5) → `vend_valid` with `vend_idx` = 4, credit = 5. Select 4 twice more → second vend leaves credit 0; third has no effect.
- Credit 7 with `change_req`, `chg_ready` held high → offered coins 500, 100, 100 on consecutive cycles; credit reaches 0; FSM returns to IDLE.
- Credit 60, insert 1000 → `coin_reject`, credit stays 60. A coin arriving during CHANGE → `coin_reject`. `coin_code` = 3 → `coin_reject`.
- Buy product 0 five times from credit 5 (STOCK_INIT = 4) → four vends; `stock_empty[0]` = 1 and `can_buy[0]` = 0. Then pulse refill → `stock_empty[0]` = 0.
- Edge-case timing:
  - `coin_valid` and `sel_valid` in the same cycle → only the selection is serviced and `coin_reject` pulses.
  - `chg_ready` held low for 3 cycles → `chg_coin` stays stable.
  - `rst_n` low mid-change → credit = 0 and `chg_valid` = 0 after the next edge.
